// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the fetch-side instruction buffer.
//   FQ_WIDTH   - default instruction / PC+4 field width
//   FQ_DEPTH   - default number of buffered entries
//   NOP_INSTR  - bubble instruction presented to decode when the buffer is empty
//   fq_entry_t - one buffered {instruction, PC+4} pair at the default width
package fetch_pkg;

    localparam int FQ_WIDTH = 32;
    localparam int FQ_DEPTH = 4;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [FQ_WIDTH-1:0] instr;
        logic [FQ_WIDTH-1:0] pc4;
    } fq_entry_t;

endpackage

// File: rtl/fq_storage.sv
// fq_storage: DEPTH x DW register array backing the fetch queue.
//   clk   in  system clock
//   we    in  write enable, sampled on the rising edge
//   waddr in  write address
//   wdata in  write data
//   raddr in  read address
//   rdata out combinational read data
// Contents are intentionally not reset; occupancy tracking in the parent
// decides which entries are meaningful.
module fq_storage
    import fetch_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int DW    = 2 * FQ_WIDTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction buffer between fetch and decode.
//   clk       in  system clock
//   reset     in  asynchronous active-low reset
//   in_valid  in  fetch presents an {instr, pc4} pair
//   in_instr  in  instruction word
//   in_pc4    in  PC+4 of that instruction
//   STALL     out hold the fetch PC (buffer full)
//   flush     in  discard all buffered entries
//   out_valid out head entry valid for decode
//   out_instr out head instruction, NOP when empty
//   out_pc4   out head PC+4, zero when empty
//   out_ready in  decode consumes the head
//   count     out current occupancy 0..DEPTH
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int WIDTH = FQ_WIDTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_instr,
    input  logic [WIDTH-1:0] in_pc4,
    output logic             STALL,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_instr,
    output logic [WIDTH-1:0] out_pc4,
    input  logic             out_ready,
    output logic [AW:0]      count
);

    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] ONE_P   = AW'(1);

    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic               full, empty, push, pop, wr_en;
    logic [2*WIDTH-1:0] head_data;

    // Flags come only from registered count, so STALL has no input path.
    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign push  = in_valid & ~full;
    assign pop   = ~empty & out_ready;
    // A flushed cycle's push must not land in storage either.
    assign wr_en = push & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            // Everything between rd_ptr and wr_ptr is wrong-path; drop it.
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + ONE_P;
            if (pop)  rd_ptr_d = rd_ptr_q + ONE_P;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    fq_storage #(
        .DEPTH (DEPTH),
        .DW    (2 * WIDTH)
    ) u_storage (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata ({in_instr, in_pc4}),
        .raddr (rd_ptr_q),
        .rdata (head_data)
    );

    assign STALL     = full;
    assign out_valid = ~empty;
    assign out_instr = empty ? WIDTH'(NOP_INSTR) : head_data[2*WIDTH-1:WIDTH];
    assign out_pc4   = empty ? '0 : head_data[WIDTH-1:0];
    assign count     = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc4;
    logic        STALL;
    logic        flush;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc4;
    logic        out_ready;
    logic [2:0]  count;

    int passed = 0;
    int total  = 0;

    fq_entry_t sb[$];

    always #5 clk = ~clk;

    fetch_queue dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_instr  (in_instr),
        .in_pc4    (in_pc4),
        .STALL     (STALL),
        .flush     (flush),
        .out_valid (out_valid),
        .out_instr (out_instr),
        .out_pc4   (out_pc4),
        .out_ready (out_ready),
        .count     (count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Outputs that depend only on the model's occupancy.
    task automatic check_state(input string tag);
        check({tag, ".count"}, 32'(count), 32'(sb.size()));
        check({tag, ".stall"}, 32'(STALL), 32'(sb.size() == 4));
        check({tag, ".valid"}, 32'(out_valid), 32'(sb.size() != 0));
        if (sb.size() == 0) begin
            check({tag, ".nop"}, out_instr, NOP_INSTR);
            check({tag, ".pc0"}, out_pc4, 32'h0);
        end
    endtask

    // Called at a falling edge; leaves the bench at the next falling edge.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] p,
                        input logic rdy, input logic fl);
        bit pop_now, push_now;
        in_valid  = v;
        in_instr  = ins;
        in_pc4    = p;
        out_ready = rdy;
        flush     = fl;
        #1;
        check_state("step");
        pop_now  = (sb.size() != 0) && rdy && !fl;
        push_now = v && (sb.size() < 4) && !fl;
        if (fl) sb.delete();
        if (pop_now) begin
            check("pop.instr", out_instr, sb[0].instr);
            check("pop.pc4", out_pc4, sb[0].pc4);
            void'(sb.pop_front());
        end
        if (push_now) sb.push_back('{instr: ins, pc4: p});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    logic [31:0] prog [4];
    logic [31:0] w;

    initial begin
        prog[0] = 32'h2008_0005;
        prog[1] = 32'h2009_0003;
        prog[2] = 32'h0109_5020;
        prog[3] = 32'hAC0A_0000;

        // Reset held with fetch presenting data: nothing may enter.
        reset = 1'b0; in_valid = 1'b1; in_instr = 32'hDEAD_BEEF; in_pc4 = 32'h100;
        out_ready = 1'b0; flush = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check_state("rst");
        end
        @(negedge clk);
        reset = 1'b1;

        // Fill, reject a fifth word, then drain in order.
        for (int i = 0; i < 4; i++) step(1'b1, prog[i], 32'(4 * (i + 1)), 1'b0, 1'b0);
        step(1'b1, 32'h1111_2222, 32'd20, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        idle();

        // Concurrent push/pop at occupancy 2, wr_ptr wraps.
        for (int i = 0; i < 2; i++) step(1'b1, $urandom, 32'(100 + 4 * i), 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, $urandom, 32'(200 + 4 * i), 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        idle();

        // Full with pop: push blocked, same word accepted next cycle.
        for (int i = 0; i < 4; i++) step(1'b1, $urandom, 32'(300 + 4 * i), 1'b0, 1'b0);
        w = 32'h5A5A_1234;
        step(1'b1, w, 32'd400, 1'b1, 1'b0);
        step(1'b1, w, 32'd400, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        idle();

        // Flush with a same-cycle push; the flushed word must never surface.
        for (int i = 0; i < 3; i++) step(1'b1, $urandom, 32'(500 + 4 * i), 1'b0, 1'b0);
        step(1'b1, 32'hF00D_F00D, 32'd600, 1'b1, 1'b1);
        idle();
        step(1'b1, 32'hCAFE_0001, 32'd604, 1'b0, 1'b1);
        idle();
        step(1'b1, 32'hCAFE_0002, 32'd608, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        idle();

        // Asynchronous reset between edges at occupancy 2.
        for (int i = 0; i < 2; i++) step(1'b1, $urandom, 32'(700 + 4 * i), 1'b0, 1'b0);
        in_valid = 1'b0;
        #1 reset = 1'b0;
        #1;
        sb.delete();
        check("arst.count", 32'(count), 32'h0);
        check("arst.valid", 32'(out_valid), 32'h0);
        check("arst.instr", out_instr, NOP_INSTR);
        @(negedge clk);
        reset = 1'b1;
        idle();
        step(1'b1, 32'h0BAD_CAFE, 32'd800, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction buffer on the receive side of the fetch stage.
- Accepts {instruction, PC+4} pairs from fetch and holds them in a circular FIFO.
- Presents the oldest pair to decode using a valid/ready handshake.
- Drives STALL back to fetch when full, so the program counter holds. A flush from branch resolution discards all buffered, wrong-path entries.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- WIDTH, 32, width of the instruction and PC+4 fields.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch is presenting a valid instruction this cycle.
- in_instr  in  WIDTH  instruction word from instruction memory.
- in_pc4  in  WIDTH  PC+4 of that instruction.
- STALL  out  1  to fetch PC register; high means hold the PC.
- flush  in  1  branch or jump taken; discard buffered contents.
- out_valid  out  1  head entry is valid for decode.
- out_instr  out  WIDTH  head instruction; NOP (32'h00000000) when empty.
- out_pc4  out  WIDTH  head PC+4; zero when empty.
- out_ready  in  1  decode consumes the head this cycle.
- count  out  AW+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (reset=0, async):
  - wr_ptr=0, rd_ptr=0, count=0.
  - out_valid=0, out_instr=NOP, out_pc4=0, STALL=0.
  - Storage contents are don't-care.
  - Reset mid-operation discards everything immediately, with no wait for a clock edge.
- Full and empty flags:
  - full = (count==DEPTH); empty = (count==0).
  - STALL = full, combinational from registered count only, with no path from in_valid or out_ready.
- Transfers:
  - push = in_valid & ~full.
  - pop = out_valid & out_ready, where out_valid = ~empty.
- Latency:
  - A pushed entry is visible at the outputs on the cycle after its push edge.
  - There is no input-to-output bypass when empty.
- Push and pop in the same cycle:
  - Both proceed; count is unchanged and both pointers advance.
  - When full, push is blocked even if pop occurs. STALL is already high, so fetch re-presents the same instruction next cycle and nothing is lost.
- Pointers:
  - Both pointers wrap modulo DEPTH.
  - count increments on push only, decrements on pop only, and holds on both or neither.
- Head outputs:
  - out_instr and out_pc4 are driven from storage[rd_ptr] when ~empty.
  - Otherwise they are forced to NOP and 0, so decode sees a bubble.
- Flush:
  - On a clock edge with flush=1, set count=0 and rd_ptr=wr_ptr.
  - Any same-cycle push or pop is ignored.
  - The next cycle shows out_valid=0 and STALL=0.
  - Flush while already empty has no effect beyond the ignored push.
- Error handling: out_ready while empty and in_valid while full are legal no-ops.

Decomposition:
- Package fetch_pkg:
  - NOP_INSTR = 32'h00000000.
  - Default WIDTH and DEPTH constants.
  - Struct fq_entry_t {instr, pc4}.
- One sub-module, fq_storage:
  - DEPTH x 2*WIDTH register array.
  - Synchronous write port (we, waddr, wdata) and combinational read port (raddr, rdata).
  - No reset on storage.
- Pointers, count, flags and the flush logic stay in fetch_queue.

Test Plan:
- Reset: hold reset=0 with in_valid=1 for 3 cycles -> out_valid=0, count=0, STALL=0, out_instr=32'h00000000. Release reset -> first push appears next cycle.
- Fill and drain: push 0x20080005, 0x20090003, 0x01095020, 0xAC0A0000 (pc4 4,8,12,16) with out_ready=0 -> count=4, STALL=1; a 5th in_valid is not accepted. Then out_ready=1 -> the four entries come out in order, pc4 4..16, one per cycle, and STALL drops on the first pop.
- Simultaneous push and pop at count=2 over 6 cycles -> count stays 2 and ordering is preserved across pointer wrap (wr_ptr passes 3 to 0).
- Full with pop: count=4, in_valid=1, out_ready=1 -> pop occurs, push is blocked, count=3. Next cycle STALL=0 and the same word is accepted, count=4.
- Flush: count=3, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, out_instr=NOP. The flushed-cycle word never appears at the output.
- Async reset mid-stream: assert reset between edges at count=2 -> out_valid and count go to 0 before the next rising edge.
